dds_sweep_gen: RTL and testbench

Parametrised multi-waveform DDS core with phase-continuous register updates and a linear frequency sweep engine. It generates sine (via external synchronous ROM), square (programmable duty), triangle and sawtooth from one phase accumulator. It sits between the control/register logic and the D/A output driver, and is clocked by the PLL-derived DDS clock.

---
 rtl/dds_sweep_gen.sv | 203 ++++++++++++++++++++
 tb/tb_dds_sweep_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_gen.sv
// Multi-waveform DDS core: phase accumulator, linear frequency sweep and a
// 3-stage waveform pipeline (sine from external sync ROM, square, triangle, sawtooth).
module dds_sweep_gen #(
    parameter int ACC_W = 32,
    parameter int PH_W  = 8,
    parameter int DA_W  = 8,
    parameter int DIV_W = 16
) (
    input  logic             DDS_CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic [ACC_W-1:0] FREQW,
    input  logic [PH_W-1:0]  PHASEW,
    input  logic [1:0]       MODE,
    input  logic [PH_W-1:0]  DUTY,
    input  logic             SWEEP_EN,
    input  logic [ACC_W-1:0] FREQ_STOP,
    input  logic [ACC_W-1:0] SWEEP_STEP,
    input  logic [DIV_W-1:0] SWEEP_DIV,
    output logic [PH_W-1:0]  ROM_ADDR,
    input  logic [DA_W-1:0]  ROM_Q,
    output logic [DA_W-1:0]  DA_DB,
    output logic             DA_VALID,
    output logic             SYNC,
    output logic             PENDING,
    output logic             SWEEP_DONE,
    output logic [ACC_W-1:0] FREQ_CUR
);

    typedef enum logic [1:0] {IDLE, SWEEP, HOLD} sweep_state_t;

    sweep_state_t     state;

    logic [ACC_W-1:0] sh_freq;
    logic [PH_W-1:0]  sh_phase;
    logic [1:0]       sh_mode;
    logic [PH_W-1:0]  sh_duty;
    logic             sh_sweep_en;
    logic [ACC_W-1:0] sh_stop;
    logic [ACC_W-1:0] sh_step;
    logic [DIV_W-1:0] sh_div;

    logic [PH_W-1:0]  phase_act;
    logic [1:0]       mode_act;
    logic [PH_W-1:0]  duty_act;
    logic [ACC_W-1:0] stop_act;
    logic [ACC_W-1:0] step_act;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_cnt;

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W:0]   sweep_sum;
    logic             carry;
    logic             apply;
    logic             start_hold;

    logic [1:0]       mode_s1;
    logic [PH_W-1:0]  duty_s1;
    logic [PH_W-1:0]  p_s2;
    logic [1:0]       mode_s2;
    logic [PH_W-1:0]  duty_s2;
    logic [2:0]       valid_sr;
    logic [PH_W-1:0]  tri_ph;
    logic [DA_W-1:0]  wave;

    function automatic logic [DA_W-1:0] left_align(input logic [PH_W-1:0] v);
        logic [PH_W+DA_W-1:0] wide;
        wide = {v, {DA_W{1'b0}}};
        return wide[PH_W+DA_W-1 -: DA_W];
    endfunction

    // The carry of the wrapping add is also the phase-continuous apply point.
    assign acc_sum    = {1'b0, acc} + {1'b0, FREQ_CUR};
    assign carry      = acc_sum[ACC_W];
    assign apply      = PENDING && (carry || (FREQ_CUR == '0));
    assign sweep_sum  = {1'b0, FREQ_CUR} + {1'b0, step_act};
    assign start_hold = sh_sweep_en && ((sh_stop <= sh_freq) || (sh_step == '0));
    assign DA_VALID   = valid_sr[2];

    always_ff @(posedge DDS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_freq     <= '0;
            sh_phase    <= '0;
            sh_mode     <= '0;
            sh_duty     <= '0;
            sh_sweep_en <= 1'b0;
            sh_stop     <= '0;
            sh_step     <= '0;
            sh_div      <= '0;
            PENDING     <= 1'b0;
        end else if (LOAD) begin
            sh_freq     <= FREQW;
            sh_phase    <= PHASEW;
            sh_mode     <= MODE;
            sh_duty     <= DUTY;
            sh_sweep_en <= SWEEP_EN;
            sh_stop     <= FREQ_STOP;
            sh_step     <= SWEEP_STEP;
            sh_div      <= SWEEP_DIV;
            PENDING     <= 1'b1;
        end else if (apply) begin
            PENDING     <= 1'b0;
        end
    end

    always_ff @(posedge DDS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc  <= '0;
            SYNC <= 1'b0;
        end else begin
            acc  <= acc_sum[ACC_W-1:0];
            SYNC <= carry;
        end
    end

    // Apply has priority over a sweep step landing on the same edge.
    always_ff @(posedge DDS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            FREQ_CUR   <= '0;
            phase_act  <= '0;
            mode_act   <= '0;
            duty_act   <= '0;
            stop_act   <= '0;
            step_act   <= '0;
            div_act    <= '0;
            div_cnt    <= '0;
            SWEEP_DONE <= 1'b0;
        end else begin
            SWEEP_DONE <= 1'b0;
            if (apply) begin
                FREQ_CUR  <= sh_freq;
                phase_act <= sh_phase;
                mode_act  <= sh_mode;
                duty_act  <= sh_duty;
                stop_act  <= sh_stop;
                step_act  <= sh_step;
                div_act   <= sh_div;
                div_cnt   <= '0;
                if (!sh_sweep_en) begin
                    state <= IDLE;
                end else if (start_hold) begin
                    state      <= HOLD;
                    SWEEP_DONE <= 1'b1;
                end else begin
                    state <= SWEEP;
                end
            end else if (state == SWEEP) begin
                if (div_cnt == div_act) begin
                    div_cnt <= '0;
                    if (sweep_sum >= {1'b0, stop_act}) begin
                        FREQ_CUR   <= stop_act;
                        state      <= HOLD;
                        SWEEP_DONE <= 1'b1;
                    end else begin
                        FREQ_CUR <= sweep_sum[ACC_W-1:0];
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    always_comb begin
        tri_ph = {p_s2[PH_W-2:0], 1'b0};
        if (p_s2[PH_W-1]) begin
            tri_ph = ~tri_ph;
        end
        wave = '0;
        case (mode_s2)
            2'd0:    wave = ROM_Q;
            2'd1:    wave = (p_s2 < duty_s2) ? '1 : '0;
            2'd2:    wave = left_align(tri_ph);
            default: wave = left_align(p_s2);
        endcase
    end

    // Mode and duty ride alongside the phase so a sample never mixes configurations.
    always_ff @(posedge DDS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            ROM_ADDR <= '0;
            mode_s1  <= '0;
            duty_s1  <= '0;
            p_s2     <= '0;
            mode_s2  <= '0;
            duty_s2  <= '0;
            DA_DB    <= '0;
            valid_sr <= '0;
        end else begin
            ROM_ADDR <= acc[ACC_W-1 -: PH_W] + phase_act;
            mode_s1  <= mode_act;
            duty_s1  <= duty_act;
            p_s2     <= ROM_ADDR;
            mode_s2  <= mode_s1;
            duty_s2  <= duty_s1;
            DA_DB    <= wave;
            valid_sr <= {valid_sr[1:0], 1'b1};
        end
    end

endmodule

// File: tb/tb_dds_sweep_gen.sv
// Directed bench for dds_sweep_gen: expected D/A samples are queued when
// stimulus is driven and compared as the pipeline delivers them.
module tb_dds_sweep_gen;

    localparam int ACC_W = 32;
    localparam int PH_W  = 8;
    localparam int DA_W  = 8;
    localparam int DIV_W = 16;

    logic             DDS_CLK;
    logic             RST_N;
    logic             LOAD;
    logic [ACC_W-1:0] FREQW;
    logic [PH_W-1:0]  PHASEW;
    logic [1:0]       MODE;
    logic [PH_W-1:0]  DUTY;
    logic             SWEEP_EN;
    logic [ACC_W-1:0] FREQ_STOP;
    logic [ACC_W-1:0] SWEEP_STEP;
    logic [DIV_W-1:0] SWEEP_DIV;
    logic [PH_W-1:0]  ROM_ADDR;
    logic [DA_W-1:0]  ROM_Q;
    logic [DA_W-1:0]  DA_DB;
    logic             DA_VALID;
    logic             SYNC;
    logic             PENDING;
    logic             SWEEP_DONE;
    logic [ACC_W-1:0] FREQ_CUR;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic            chk;
        logic [DA_W-1:0] da;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    string     cur_tag;

    dds_sweep_gen #(
        .ACC_W(ACC_W), .PH_W(PH_W), .DA_W(DA_W), .DIV_W(DIV_W)
    ) dut (
        .DDS_CLK   (DDS_CLK),
        .RST_N     (RST_N),
        .LOAD      (LOAD),
        .FREQW     (FREQW),
        .PHASEW    (PHASEW),
        .MODE      (MODE),
        .DUTY      (DUTY),
        .SWEEP_EN  (SWEEP_EN),
        .FREQ_STOP (FREQ_STOP),
        .SWEEP_STEP(SWEEP_STEP),
        .SWEEP_DIV (SWEEP_DIV),
        .ROM_ADDR  (ROM_ADDR),
        .ROM_Q     (ROM_Q),
        .DA_DB     (DA_DB),
        .DA_VALID  (DA_VALID),
        .SYNC      (SYNC),
        .PENDING   (PENDING),
        .SWEEP_DONE(SWEEP_DONE),
        .FREQ_CUR  (FREQ_CUR)
    );

    initial begin
        DDS_CLK = 1'b0;
        forever #5 DDS_CLK = ~DDS_CLK;
    end

    // Bijective table so a wrong ROM address always shows up as a wrong sample.
    function automatic logic [7:0] rom_val(input logic [7:0] a);
        logic [15:0] v;
        v = {8'd0, a} * 16'd37 + 16'd11;
        return v[7:0];
    endfunction

    always @(posedge DDS_CLK) ROM_Q <= rom_val(ROM_ADDR);

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        sb_entry_t e;
        @(negedge DDS_CLK);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk) check_output(cur_tag, 64'(DA_DB), 64'(e.da));
        end
    endtask

    task automatic drain();
        while (sb_q.size() > 0) step();
    endtask

    task automatic push_dc(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back('{chk: 1'b0, da: '0});
    endtask

    task automatic push_da(input logic [DA_W-1:0] v);
        sb_q.push_back('{chk: 1'b1, da: v});
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        LOAD  = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge DDS_CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge DDS_CLK);
    endtask

    task automatic apply_stimulus(input logic [ACC_W-1:0] f, input logic [PH_W-1:0] ph,
                                  input logic [1:0] m, input logic [PH_W-1:0] d,
                                  input logic se, input logic [ACC_W-1:0] stop,
                                  input logic [ACC_W-1:0] stp, input logic [DIV_W-1:0] dv);
        FREQW      = f;
        PHASEW     = ph;
        MODE       = m;
        DUTY       = d;
        SWEEP_EN   = se;
        FREQ_STOP  = stop;
        SWEEP_STEP = stp;
        SWEEP_DIV  = dv;
        LOAD       = 1'b1;
        step();
        LOAD       = 1'b0;
    endtask

    initial begin
        logic [ACC_W-1:0] exp_f;
        logic [ACC_W-1:0] stop2;
        int               j;
        int               p;

        RST_N = 1'b0; LOAD = 1'b0; FREQW = '0; PHASEW = '0; MODE = '0; DUTY = '0;
        SWEEP_EN = 1'b0; FREQ_STOP = '0; SWEEP_STEP = '0; SWEEP_DIV = '0;

        // Reset state and DA_VALID ramp
        repeat (2) @(negedge DDS_CLK);
        check_output("rst_da", 64'(DA_DB), 0);
        check_output("rst_addr", 64'(ROM_ADDR), 0);
        check_output("rst_freq", 64'(FREQ_CUR), 0);
        check_output("rst_flags", 64'({DA_VALID, SYNC, PENDING, SWEEP_DONE}), 0);
        RST_N = 1'b1;
        step(); step();
        check_output("valid_low", 64'(DA_VALID), 0);
        step();
        check_output("valid_high", 64'(DA_VALID), 1);

        // Sawtooth
        do_reset();
        cur_tag = "saw_da";
        push_dc(4);
        for (int n = 0; n < 300; n++) push_da(8'(n));
        apply_stimulus(32'h0100_0000, 8'd0, 2'd3, 8'd0, 1'b0, '0, '0, '0);
        check_output("saw_pending", 64'(PENDING), 1);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 1) check_output("saw_freq", 64'(FREQ_CUR), 64'h0100_0000);
            if (k == 1) check_output("saw_pending_clr", 64'(PENDING), 0);
            check_output("saw_sync", 64'(SYNC), 64'(k == 257));
        end
        drain();

        // Square, DUTY=64
        do_reset();
        cur_tag = "sq64_da";
        push_dc(4);
        for (int n = 0; n < 256; n++) push_da((n < 64) ? 8'hFF : 8'h00);
        apply_stimulus(32'h0100_0000, 8'd0, 2'd1, 8'd64, 1'b0, '0, '0, '0);
        drain();

        // Square, DUTY=0
        do_reset();
        cur_tag = "sq0_da";
        push_dc(4);
        for (int n = 0; n < 64; n++) push_da(8'h00);
        apply_stimulus(32'h0100_0000, 8'd0, 2'd1, 8'd0, 1'b0, '0, '0, '0);
        drain();

        // Triangle
        do_reset();
        cur_tag = "tri_da";
        push_dc(4);
        for (int n = 0; n < 260; n++) begin
            p = n % 256;
            push_da((p < 128) ? 8'(2 * p) : 8'(255 - 2 * (p - 128)));
        end
        apply_stimulus(32'h0100_0000, 8'd0, 2'd2, 8'd0, 1'b0, '0, '0, '0);
        drain();

        // Phase-continuous frequency change mid-period
        do_reset();
        cur_tag = "pc_da";
        push_dc(4);
        for (int n = 0; n < 256; n++) push_da(8'(n));
        for (int m = 0; m < 140; m++) push_da(8'(2 * m));
        apply_stimulus(32'h0100_0000, 8'd0, 2'd3, 8'd0, 1'b0, '0, '0, '0);
        for (int k = 1; k <= 399; k++) begin
            if (k == 101) begin
                FREQW = 32'h0200_0000;
                LOAD  = 1'b1;
            end
            step();
            LOAD = 1'b0;
            if (k == 101 || k == 256) check_output("pc_pending", 64'(PENDING), 1);
            if (k == 257) check_output("pc_pending_clr", 64'(PENDING), 0);
            if (k == 256) check_output("pc_freq_old", 64'(FREQ_CUR), 64'h0100_0000);
            if (k == 257) check_output("pc_freq_new", 64'(FREQ_CUR), 64'h0200_0000);
            if (k == 257) check_output("pc_sync", 64'(SYNC), 1);
        end
        drain();

        // Sweep to exact stop after 10 steps
        do_reset();
        apply_stimulus(32'h0010_0000, 8'd0, 2'd3, 8'd0, 1'b1,
                       32'h0010_0000 + 32'd10 * 32'h0001_0000, 32'h0001_0000, 16'd3);
        for (int k = 1; k <= 60; k++) begin
            step();
            j = (k - 1) / 4;
            if (j > 10) j = 10;
            exp_f = 32'h0010_0000 + 32'(j) * 32'h0001_0000;
            check_output("sw_freq", 64'(FREQ_CUR), 64'(exp_f));
            check_output("sw_done", 64'(SWEEP_DONE), 64'(k == 41));
        end

        // Sweep clamped to a stop that is not a whole step multiple
        do_reset();
        stop2 = 32'h0010_0000 + 32'd5 * 32'h0001_0000 + 32'd1;
        apply_stimulus(32'h0010_0000, 8'd0, 2'd3, 8'd0, 1'b1, stop2, 32'h0001_0000, 16'd3);
        for (int k = 1; k <= 40; k++) begin
            step();
            j = (k - 1) / 4;
            exp_f = (j >= 6) ? stop2 : 32'h0010_0000 + 32'(j) * 32'h0001_0000;
            check_output("swc_freq", 64'(FREQ_CUR), 64'(exp_f));
            check_output("swc_done", 64'(SWEEP_DONE), 64'(k == 25));
        end

        // Stop not above start: straight to hold with a done pulse at apply
        do_reset();
        apply_stimulus(32'h0010_0000, 8'd0, 2'd3, 8'd0, 1'b1, 32'h0010_0000, 32'h0001_0000, 16'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check_output("swh_freq", 64'(FREQ_CUR), 64'h0010_0000);
            check_output("swh_done", 64'(SWEEP_DONE), 64'(k == 1));
        end

        // Sine through the external ROM with a phase offset
        do_reset();
        cur_tag = "sine_da";
        push_dc(4);
        for (int n = 0; n < 300; n++) push_da(rom_val(8'((n + 64) % 256)));
        apply_stimulus(32'h0100_0000, 8'd64, 2'd0, 8'd0, 1'b0, '0, '0, '0);
        for (int k = 1; k <= 303; k++) begin
            step();
            if (k >= 2) check_output("sine_addr", 64'(ROM_ADDR), 64'((k - 2 + 64) % 256));
        end
        drain();

        // Asynchronous reset mid-sweep with a pending load
        do_reset();
        apply_stimulus(32'h0010_0000, 8'd100, 2'd3, 8'd0, 1'b1,
                       32'h0010_0000 + 32'd10 * 32'h0001_0000, 32'h0001_0000, 16'd3);
        repeat (20) step();
        FREQW    = 32'h0100_0000;
        SWEEP_EN = 1'b0;
        LOAD     = 1'b1;
        step();
        LOAD = 1'b0;
        check_output("mid_pending", 64'(PENDING), 1);
        #2;
        RST_N = 1'b0;
        #1;
        check_output("async_da", 64'(DA_DB), 0);
        check_output("async_addr", 64'(ROM_ADDR), 0);
        check_output("async_freq", 64'(FREQ_CUR), 0);
        check_output("async_flags", 64'({DA_VALID, SYNC, PENDING, SWEEP_DONE}), 0);
        @(negedge DDS_CLK);
        RST_N = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 2) check_output("post_valid_low", 64'(DA_VALID), 0);
            if (k == 3) check_output("post_valid_high", 64'(DA_VALID), 1);
            check_output("post_freq", 64'(FREQ_CUR), 0);
            check_output("post_addr", 64'(ROM_ADDR), 0);
            check_output("post_flags", 64'({SYNC, PENDING, SWEEP_DONE}), 0);
            if (k >= 3) check_output("post_da", 64'(DA_DB), 64'(rom_val(8'd0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
